qos_read_sequencer: RTL

Drains the four priority buffers according to the one-hot 4-bit buffer-select produced by the QoS selector. It converts each selection into a single-cycle read strobe to the chosen buffer and captures the returned word. The word is presented on a valid/ready output port toward the transmit stage. The block sits between the QoS selector, the four buffer FIFOs and the downstream consumer.

---
 rtl/qos_read_sequencer_if.sv | 40 ++++
 rtl/qos_read_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/qos_read_sequencer_if.sv
// Bundles the selector, buffer and consumer-side signals of qos_read_sequencer.
// slave is the sequencer's view; master is the environment driving it.
interface qos_read_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 3
);
  logic [3:0]        read_from;
  logic [CNT_W-1:0]  current_data_count0;
  logic [CNT_W-1:0]  current_data_count1;
  logic [CNT_W-1:0]  current_data_count2;
  logic [CNT_W-1:0]  current_data_count3;
  logic [DATA_W-1:0] buf_data0;
  logic [DATA_W-1:0] buf_data1;
  logic [DATA_W-1:0] buf_data2;
  logic [DATA_W-1:0] buf_data3;
  logic [3:0]        rd_en;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_src;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        served_cnt;

  modport slave (
    input  read_from,
    input  current_data_count0, current_data_count1,
    input  current_data_count2, current_data_count3,
    input  buf_data0, buf_data1, buf_data2, buf_data3,
    input  out_ready,
    output rd_en, out_data, out_src, out_valid, served_cnt
  );

  modport master (
    output read_from,
    output current_data_count0, current_data_count1,
    output current_data_count2, current_data_count3,
    output buf_data0, buf_data1, buf_data2, buf_data3,
    output out_ready,
    input  rd_en, out_data, out_src, out_valid, served_cnt
  );
endinterface

// File: rtl/qos_read_sequencer.sv
// Turns one-hot QoS grants into single-cycle buffer reads and presents the word on valid/ready.
// Optional starvation override enabled by defining QOS_AGING_EN.
//
// state     | meaning
// ----------|------------------------------------------------------------
// S_IDLE    | waiting for a legal grant (or aging override)
// S_READ    | rd_en[sel] strobed for exactly this cycle
// S_CAPTURE | buffer data valid; registered into out_data at exit
// S_HOLD    | out_valid asserted until consumer accepts
module qos_read_sequencer #(
  parameter int DATA_W       = 8,
  parameter int CNT_W        = 3,
  parameter int STARVE_LIMIT = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  qos_read_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_CAPTURE, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_src_q, out_src_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        served_q, served_d;

  logic [CNT_W-1:0]  cnt [4];
  logic [DATA_W-1:0] bdata [4];

  assign cnt[0]   = bus.current_data_count0;
  assign cnt[1]   = bus.current_data_count1;
  assign cnt[2]   = bus.current_data_count2;
  assign cnt[3]   = bus.current_data_count3;
  assign bdata[0] = bus.buf_data0;
  assign bdata[1] = bus.buf_data1;
  assign bdata[2] = bus.buf_data2;
  assign bdata[3] = bus.buf_data3;

  logic       xfer;
  logic       grant_ok;
  logic [1:0] grant_idx;
  logic       pick_ok;
  logic [1:0] pick_idx;

  assign xfer = (state_q == S_HOLD) && out_valid_q && bus.out_ready;

  // Only a strictly one-hot grant onto a non-empty buffer is accepted.
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = 2'd0;
    case (bus.read_from)
      4'b0001: begin grant_ok = 1'b1; grant_idx = 2'd0; end
      4'b0010: begin grant_ok = 1'b1; grant_idx = 2'd1; end
      4'b0100: begin grant_ok = 1'b1; grant_idx = 2'd2; end
      4'b1000: begin grant_ok = 1'b1; grant_idx = 2'd3; end
      default: begin grant_ok = 1'b0; grant_idx = 2'd0; end
    endcase
    if (cnt[grant_idx] == '0) grant_ok = 1'b0;
  end

`ifdef QOS_AGING_EN
  localparam int AGE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic [AGE_W-1:0] age_q [4];
  logic [AGE_W-1:0] age_d [4];
  logic             age_hit;
  logic [1:0]       age_idx;

  // Descending scan so the lowest starved index wins.
  always_comb begin
    age_hit = 1'b0;
    age_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if ((age_q[i] == AGE_MAX) && (cnt[i] != '0)) begin
        age_hit = 1'b1;
        age_idx = 2'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      age_d[i] = age_q[i];
      if (xfer) begin
        if (2'(i) == sel_q)
          age_d[i] = '0;
        else if ((cnt[i] != '0) && (age_q[i] < AGE_MAX))
          age_d[i] = age_q[i] + 1'b1;
      end
      if (cnt[i] == '0) age_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) age_q[i] <= age_d[i];
    end
  end

  assign pick_ok  = age_hit | grant_ok;
  assign pick_idx = age_hit ? age_idx : grant_idx;
`else
  assign pick_ok  = grant_ok;
  assign pick_idx = grant_idx;
`endif

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    served_d    = served_q;
    case (state_q)
      S_IDLE: begin
        if (pick_ok) begin
          sel_d   = pick_idx;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_CAPTURE;
      S_CAPTURE: begin
        out_data_d  = bdata[sel_q];
        out_src_d   = sel_q;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          served_d    = served_q + 8'd1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sel_q       <= 2'd0;
      out_data_q  <= '0;
      out_src_q   <= 2'd0;
      out_valid_q <= 1'b0;
      served_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      served_q    <= served_d;
    end
  end

  // Strobe is decoded from the state so an async reset removes it immediately.
  assign bus.rd_en      = (state_q == S_READ) ? (4'b0001 << sel_q) : 4'b0000;
  assign bus.out_data   = out_data_q;
  assign bus.out_src    = out_src_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.served_cnt = served_q;

endmodule
